// File: rtl/alu_multicycle.sv
// alu_multicycle: valid/ready ALU; add/sub/logic/shift finish in 1 cycle,
// mul/div/mod iterate one bit per cycle over N cycles (N+1 cycle latency).
// Ports: clk, rst (async, active-high), in_valid/in_ready + a, b, ctrl request;
//        out_valid/out_ready + res, flags {neg, zero, carry, overflow} result.
// Backpressure: res/flags held while out_ready=0; in_ready only in IDLE.
module alu_multicycle #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ctrl,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] res,
    output logic [3:0]   flags
);
    localparam int SW = $clog2(N);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_MOD = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_OR  = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1000;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    logic [3:0]    op_r;
    logic [SW-1:0] cnt;
    // Shared iteration registers.
    // mul: acc = partial product, opa = multiplicand (shifts left), opb = multiplier (shifts right)
    // div: acc = partial remainder, opa = dividend shifting out / quotient shifting in, opb = divisor
    logic [N-1:0]  acc, opa, opb;

    // Single-cycle datapath, evaluated on the request inputs directly.
    logic          sub_op;
    logic [N-1:0]  bx;
    logic [N:0]    sum;
    logic [N-1:0]  quick_res;
    logic          quick_c, quick_v;

    always_comb begin
        sub_op    = (ctrl == OP_SUB);
        bx        = sub_op ? ~b : b;
        sum       = {1'b0, a} + {1'b0, bx} + {{N{1'b0}}, sub_op};
        quick_res = '0;
        quick_c   = 1'b0;
        quick_v   = 1'b0;
        case (ctrl)
            OP_ADD, OP_SUB: begin
                quick_res = sum[N-1:0];
                quick_c   = sum[N];
                quick_v   = (a[N-1] == bx[N-1]) && (sum[N-1] != a[N-1]);
            end
            OP_AND:  quick_res = a & b;
            OP_OR:   quick_res = a | b;
            OP_SHR:  quick_res = a >> b[SW-1:0];
            OP_SHL:  quick_res = a << b[SW-1:0];
            default: quick_res = '0;
        endcase
    end

    // One iteration of shift-add multiply or restoring divide.
    logic [N:0]   rem_sh, rem_sub;
    logic [N-1:0] acc_nx, opa_nx, opb_nx;
    logic [N-1:0] fin_res;
    logic         fin_v;

    always_comb begin
        rem_sh  = {acc, opa[N-1]};
        rem_sub = rem_sh - {1'b0, opb};
        acc_nx  = acc;
        opa_nx  = opa;
        opb_nx  = opb;
        if (op_r == OP_MUL) begin
            acc_nx = acc + (opb[0] ? opa : '0);
            opa_nx = opa << 1;
            opb_nx = opb >> 1;
        end else if (rem_sh >= {1'b0, opb}) begin
            // A zero divisor always "fits", which yields all-ones quotient and remainder = a.
            acc_nx = rem_sub[N-1:0];
            opa_nx = {opa[N-2:0], 1'b1};
        end else begin
            acc_nx = rem_sh[N-1:0];
            opa_nx = {opa[N-2:0], 1'b0};
        end
        fin_res = (op_r == OP_DIV) ? opa_nx : acc_nx;
        fin_v   = (op_r != OP_MUL) && (opb == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
            flags     <= 4'b0000;
            cnt       <= '0;
            op_r      <= OP_ADD;
            acc       <= '0;
            opa       <= '0;
            opb       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_r     <= ctrl;
                        in_ready <= 1'b0;
                        if (ctrl == OP_MUL || ctrl == OP_DIV || ctrl == OP_MOD) begin
                            state <= EXEC;
                            cnt   <= '0;
                            acc   <= '0;
                            opa   <= a;
                            opb   <= b;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            res       <= quick_res;
                            flags     <= {quick_res[N-1], quick_res == '0, quick_c, quick_v};
                        end
                    end
                end
                EXEC: begin
                    acc <= acc_nx;
                    opa <= opa_nx;
                    opb <= opb_nx;
                    cnt <= cnt + SW'(1);
                    if (cnt == SW'(N - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        res       <= fin_res;
                        flags     <= {fin_res[N-1], fin_res == '0, 1'b0, fin_v};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
module tb_alu_multicycle;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] a = '0;
    logic [N-1:0] b = '0;
    logic [3:0]   ctrl = 4'b0000;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] res;
    logic [3:0]   flags;

    int checks = 0;
    int errors = 0;

    alu_multicycle #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ctrl      (ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one request, measure latency (edges from acceptance until the consumer
    // sees out_valid), optionally stall out_ready for 'hold' cycles while firing
    // stray requests, then complete the handshake.
    task automatic do_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic [3:0] tc, input int exp_lat,
                         input logic [N-1:0] exp_res, input logic [3:0] exp_flags,
                         input int hold);
        int lat;
        int busy;
        @(negedge clk);
        a = ta; b = tb; ctrl = tc; in_valid = 1'b1;
        out_ready = (hold == 0);
        check({tag, ".rdy"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        // Scramble operands after the accepting edge; the DUT must have captured them.
        in_valid = 1'b0;
        a = N'($urandom); b = N'($urandom); ctrl = 4'($urandom);
        lat = 1; busy = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".busy"}, busy + int'(in_ready), 0);
        check({tag, ".res"}, {16'd0, res}, {16'd0, exp_res});
        check({tag, ".flags"}, {28'd0, flags}, {28'd0, exp_flags});
        for (int i = 0; i < hold; i++) begin
            a = 16'h0001; b = 16'h0001; ctrl = 4'b0000; in_valid = 1'b1;
            @(posedge clk); #1;
            check({tag, ".hold_vld"}, {31'd0, out_valid}, 32'd1);
            check({tag, ".hold_res"}, {16'd0, res}, {16'd0, exp_res});
            check({tag, ".hold_flags"}, {28'd0, flags}, {28'd0, exp_flags});
            check({tag, ".hold_rdy"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, ".hs_vld"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".hs_rdy"}, {31'd0, in_ready}, 32'd1);
        if (hold > 0) begin
            // Stray requests during the stall must not have queued anything.
            @(posedge clk); #1;
            check({tag, ".no_stray"}, {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    initial begin
        int seen;
        #3 rst = 1'b1;
        #1;
        check("rst.vld", {31'd0, out_valid}, 32'd0);
        check("rst.res", {16'd0, res}, 32'd0);
        check("rst.flags", {28'd0, flags}, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("rst.rdy", {31'd0, in_ready}, 32'd1);

        do_op("add_ovf",  16'h7FFF, 16'h0001, 4'b0000, 1,  16'h8000, 4'b1001, 0);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 4'b0000, 1,  16'h0000, 4'b0110, 0);
        do_op("sub_eq",   16'h0005, 16'h0005, 4'b0001, 1,  16'h0000, 4'b0110, 0);
        do_op("sub_brw",  16'h0000, 16'h0001, 4'b0001, 1,  16'hFFFF, 4'b1000, 0);
        do_op("div",      16'd100,  16'd7,    4'b0011, 17, 16'd14,   4'b0000, 0);
        do_op("mod",      16'd100,  16'd7,    4'b0100, 17, 16'd2,    4'b0000, 0);
        do_op("div0",     16'h1234, 16'h0000, 4'b0011, 17, 16'hFFFF, 4'b1001, 0);
        do_op("mod0",     16'h1234, 16'h0000, 4'b0100, 17, 16'h1234, 4'b0001, 0);
        do_op("mul_trn",  16'h0100, 16'h0100, 4'b0010, 17, 16'h0000, 4'b0100, 5);
        do_op("mul",      16'h00FF, 16'h0101, 4'b0010, 17, 16'hFFFF, 4'b1000, 0);
        do_op("and",      16'hF0F0, 16'h0FF0, 4'b0101, 1,  16'h00F0, 4'b0000, 0);
        do_op("or_zero",  16'h0000, 16'h0000, 4'b0110, 1,  16'h0000, 4'b0100, 0);
        do_op("shr",      16'h8000, 16'h0013, 4'b0111, 1,  16'h1000, 4'b0000, 0);
        do_op("shl",      16'h0003, 16'h0004, 4'b1000, 1,  16'h0030, 4'b0000, 0);
        do_op("shl_mod",  16'h0001, 16'h0010, 4'b1000, 1,  16'h0001, 4'b0000, 0);
        do_op("undef",    16'h0005, 16'h0003, 4'b1111, 1,  16'h0000, 4'b0100, 0);

        // Abort a mod mid-EXEC with an asynchronous reset pulse.
        @(negedge clk);
        a = 16'd100; b = 16'd7; ctrl = 4'b0100; in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("abort.vld", {31'd0, out_valid}, 32'd0);
        check("abort.res", {16'd0, res}, 32'd0);
        @(negedge clk); rst = 1'b0;
        #1 check("abort.rdy", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort.no_out", seen, 0);
        check("abort.res_after", {16'd0, res}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
